sample_recorder: RTL and testbench
==================================

Name: sample_recorder

Overview:
Parametrised successor of the single-shot ADC capture block. It records a continuous sample stream into an external circular RAM through an Avalon-MM master, with a programmable pre-trigger and post-trigger window. Trigger sources are selectable (software, external start edge); an optional comparator stop ends the capture early. A Nios-facing Avalon-MM slave holds control, status and pointer registers and raises an IRQ on completion. Everything runs on a single clock; samples arrive already synchronous with a valid strobe.

Parameters:
DATA_W, 8, sample and RAM data width
ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W samples

Ports:
avmms_clk  in  1  single clock for all logic
avmms_reset  in  1  synchronous, active-high reset
sample_data  in  DATA_W  ADC sample
sample_valid  in  1  sample_data valid this cycle
ext_start  in  1  external trigger level, already synchronous; rising edge used
stop_in  in  1  comparator level, already synchronous; rising edge used
avmms_cs  in  1  slave select
avmms_address  in  3  register index
avmms_write  in  1  slave write
avmms_writedata  in  32  slave write data
avmms_read  in  1  slave read
avmms_readdata  out  32  registered read data, latency 1
irq  out  1  STATUS.DONE & CONTROL.IRQ_EN
avmm_address  out  ADDR_W  RAM write address
avmm_write  out  1  RAM write strobe
avmm_writedata  out  DATA_W  RAM write data
pretrig_ready  out  1  high in ARMED state
busy  out  1  high in PRE, ARMED, POST

Behaviour:
Registers (read latency 1; unused bits read 0; undefined addresses read 0xCCCC):
- 0 CONTROL: [0] ARM (write-1 pulse, reads 0); [1] EXT_EN; [2] SW_TRIG (write-1 pulse, reads 0); [3] ABORT (write-1 pulse, reads 0); [4] IRQ_EN.
- 1 STATUS (read-only except W1C): [0] DONE (W1C); [1] BUSY; [2] SHORT_PRE; [3] STOPPED; [6:4] state code.
- 2 PRE_LEN, 3 POST_LEN: ADDR_W+1 bits each, R/W; a written value above DEPTH saturates to DEPTH.
- 4 TRIG_PTR: address of the first post-trigger sample. 5 WR_PTR: next write address.
Reset: state IDLE; all registers and pointers 0; irq, avmm_write, busy and pretrig_ready 0; avmms_readdata 0. Edge-detect flops reset to 1, so a level that is already high at reset gives no edge.
FSM (codes IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4):
- IDLE/DONE + ARM -> clear DONE, SHORT_PRE, STOPPED; wr_ptr=0; cnt=0; go to PRE, or to ARMED if PRE_LEN=0. ARM in PRE/ARMED/POST is ignored.
- Sample accept: in PRE, ARMED and POST, sample_valid drives avmm_write=1 in the same cycle, with avmm_address=wr_ptr and avmm_writedata=sample_data (combinational). wr_ptr then increments and wraps DEPTH-1 -> 0.
- PRE: count accepted samples; the sample that brings cnt to PRE_LEN moves the FSM to ARMED.
- Trigger = SW_TRIG write, or ext_start rising edge when EXT_EN=1. SW_TRIG and an external edge in the same cycle count as one trigger.
- Trigger in PRE or ARMED: TRIG_PTR<=wr_ptr, cnt=0, go to POST. A trigger in PRE also sets SHORT_PRE. Any sample accepted in the trigger cycle is the first post sample.
- Trigger in IDLE, POST or DONE is ignored.
- POST: count accepted samples; when cnt reaches POST_LEN, go to DONE. POST_LEN=0 -> DONE one cycle after the trigger, with no post samples.
- stop_in rising edge in POST -> STOPPED=1, go to DONE next cycle. A sample accepted that same cycle is still written.
- Entering DONE sets STATUS.DONE. DONE stays set until W1C or the next ARM.
- ABORT in any state -> IDLE; DONE is not set; pointers are held for readback. ABORT and ARM in the same write: ABORT wins.
- ARM and a trigger in the same cycle: ARM takes effect, the trigger is dropped.
- A slave write to PRE_LEN/POST_LEN while busy updates the register but takes effect only at the next ARM (values are latched at ARM).
- Synchronous reset mid-capture: immediate return to IDLE with all outputs 0, no RAM write in the reset cycle.
- If PRE_LEN+POST_LEN exceeds DEPTH, the RAM overwrites circularly; no error is flagged.

Test Plan:
- Reset, then read regs 0-5 -> all 0; read address 7 -> 0xCCCC; irq=0, avmm_write=0.
- PRE_LEN=4, POST_LEN=3, IRQ_EN=1, ARM, continuous valid samples 0x10.. -> after 4 samples ARMED/pretrig_ready=1; SW_TRIG at wr_ptr=6 -> TRIG_PTR=6, 3 more writes at addresses 6,7,8, DONE, irq=1; W1C STATUS -> irq=0.
- PRE_LEN=8, ext_start rising edge after 3 samples with EXT_EN=1 -> SHORT_PRE=1, TRIG_PTR=3; the same edge with EXT_EN=0 -> ignored, stays PRE.
- PRE_LEN=0, POST_LEN=DEPTH+5 -> POST_LEN reads 512; writes wrap 511 -> 0; DONE after 512 post samples.
- POST_LEN=10, stop_in rising edge after 4 post samples -> STOPPED=1, DONE, WR_PTR=TRIG_PTR+4 (or +5 if a sample was valid in the edge cycle).
- ABORT mid-POST -> IDLE, DONE=0, irq=0; avmms_reset mid-ARMED -> IDLE, all registers 0; ARM with SW_TRIG in the same write -> PRE entered, no trigger.

Source files
------------

// File: rtl/sample_recorder.sv
// sample_recorder: pre/post-trigger sample capture into a circular RAM over Avalon-MM, with a Nios register slave.
// Ports:
//   avmms_clk, avmms_reset        single clock, synchronous active-high reset
//   sample_data, sample_valid     incoming sample stream
//   ext_start, stop_in            synchronous trigger / comparator-stop levels (rising edges used)
//   avmms_*                       register slave (read latency 1), irq on completion
//   avmm_address/write/writedata  RAM write master
//   pretrig_ready, busy           capture status
module sample_recorder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              avmms_clk,
    input  logic              avmms_reset,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    input  logic              ext_start,
    input  logic              stop_in,
    input  logic              avmms_cs,
    input  logic [2:0]        avmms_address,
    input  logic              avmms_write,
    input  logic [31:0]       avmms_writedata,
    input  logic              avmms_read,
    output logic [31:0]       avmms_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] avmm_address,
    output logic              avmm_write,
    output logic [DATA_W-1:0] avmm_writedata,
    output logic              pretrig_ready,
    output logic              busy
);
    localparam int LW = ADDR_W + 1;
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
    state_t state, state_nx;

    logic ext_en, irq_en, done_f, short_pre, stopped, ext_q, stop_q;
    logic [LW-1:0] pre_len, post_len, pre_lat, post_lat, cnt, cnt_inc, sat_len;
    logic [ADDR_W-1:0] wr_ptr, trig_ptr;
    logic bus_wr, ctrl_wr, arm, sw_trig, abort, trig, stop_edge;
    logic capturing, post_full, wen, arm_go, trig_go;
    logic [31:0] rd_mux;

    assign bus_wr    = avmms_cs & avmms_write;
    assign ctrl_wr   = bus_wr && avmms_address == 3'd0;
    assign arm       = ctrl_wr & avmms_writedata[0];
    assign sw_trig   = ctrl_wr & avmms_writedata[2];
    assign abort     = ctrl_wr & avmms_writedata[3];
    assign trig      = sw_trig | (ext_en & ext_start & ~ext_q);
    assign stop_edge = stop_in & ~stop_q;
    assign capturing = state == PRE || state == ARMED || state == POST;
    // Once the post window is full no further samples are written, even if still in POST for a cycle.
    assign post_full = state == POST && cnt >= post_lat;
    assign wen       = sample_valid & capturing & ~post_full & ~abort & ~avmms_reset;
    assign arm_go    = arm & ~abort & (state == IDLE || state == DONE);
    assign trig_go   = trig & ~abort & (state == PRE || state == ARMED);
    assign cnt_inc   = cnt + 1'b1;
    assign sat_len   = avmms_writedata > DEPTH ? DEPTH[LW-1:0] : avmms_writedata[LW-1:0];

    assign avmm_write     = wen;
    assign avmm_address   = wr_ptr;
    assign avmm_writedata = sample_data;
    assign irq            = done_f & irq_en & ~avmms_reset;
    assign busy           = capturing & ~avmms_reset;
    assign pretrig_ready  = state == ARMED && !avmms_reset;

    always_comb begin
        state_nx = state;
        if (abort)
            state_nx = IDLE;
        else if (arm_go)
            state_nx = pre_len == '0 ? ARMED : PRE;
        else if (trig_go)
            state_nx = POST;
        else if (state == PRE && wen && cnt_inc == pre_lat)
            state_nx = ARMED;
        else if (state == POST && (stop_edge || post_full || (wen && cnt_inc == post_lat)))
            state_nx = DONE;
    end

    always_comb begin
        rd_mux = 32'hCCCC;
        case (avmms_address)
            3'd0: rd_mux = {27'd0, irq_en, 2'b00, ext_en, 1'b0};
            3'd1: rd_mux = {25'd0, state, stopped, short_pre, capturing, done_f};
            3'd2: rd_mux = 32'(pre_len);
            3'd3: rd_mux = 32'(post_len);
            3'd4: rd_mux = 32'(trig_ptr);
            3'd5: rd_mux = 32'(wr_ptr);
            default: ;
        endcase
    end

    always_ff @(posedge avmms_clk) begin
        if (avmms_reset) begin
            state          <= IDLE;
            ext_en         <= 1'b0;
            irq_en         <= 1'b0;
            done_f         <= 1'b0;
            short_pre      <= 1'b0;
            stopped        <= 1'b0;
            ext_q          <= 1'b1;
            stop_q         <= 1'b1;
            pre_len        <= '0;
            post_len       <= '0;
            pre_lat        <= '0;
            post_lat       <= '0;
            cnt            <= '0;
            wr_ptr         <= '0;
            trig_ptr       <= '0;
            avmms_readdata <= '0;
        end else begin
            state  <= state_nx;
            ext_q  <= ext_start;
            stop_q <= stop_in;
            if (ctrl_wr) begin
                ext_en <= avmms_writedata[1];
                irq_en <= avmms_writedata[4];
            end
            if (bus_wr && avmms_address == 3'd2)
                pre_len <= sat_len;
            if (bus_wr && avmms_address == 3'd3)
                post_len <= sat_len;
            if (wen) begin
                wr_ptr <= wr_ptr + 1'b1;
                cnt    <= cnt_inc;
            end
            // A sample accepted in the trigger cycle is already the first post sample.
            if (trig_go) begin
                trig_ptr <= wr_ptr;
                cnt      <= LW'(wen);
                if (state == PRE)
                    short_pre <= 1'b1;
            end
            if (state == POST && stop_edge && !abort)
                stopped <= 1'b1;
            if (bus_wr && avmms_address == 3'd1 && avmms_writedata[0])
                done_f <= 1'b0;
            if (state_nx == DONE && state != DONE)
                done_f <= 1'b1;
            // Window lengths are latched here so mid-capture register writes wait for the next capture.
            if (arm_go) begin
                done_f    <= 1'b0;
                short_pre <= 1'b0;
                stopped   <= 1'b0;
                wr_ptr    <= '0;
                cnt       <= '0;
                pre_lat   <= pre_len;
                post_lat  <= post_len;
            end
            if (avmms_cs && avmms_read)
                avmms_readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_sample_recorder.sv
// tb_sample_recorder: randomized scoreboard bench for sample_recorder against a behavioural capture model.
module tb_sample_recorder;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        avmms_reset;
    logic [7:0]  sample_data;
    logic        sample_valid;
    logic        ext_start, stop_in;
    logic        avmms_cs, avmms_write, avmms_read;
    logic [2:0]  avmms_address;
    logic [31:0] avmms_writedata;
    logic [31:0] avmms_readdata;
    logic        irq, avmm_write, pretrig_ready, busy;
    logic [8:0]  avmm_address;
    logic [7:0]  avmm_writedata;

    sample_recorder #(.DATA_W(8), .ADDR_W(9)) dut (
        .avmms_clk(clk), .avmms_reset(avmms_reset),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .ext_start(ext_start), .stop_in(stop_in),
        .avmms_cs(avmms_cs), .avmms_address(avmms_address), .avmms_write(avmms_write),
        .avmms_writedata(avmms_writedata), .avmms_read(avmms_read), .avmms_readdata(avmms_readdata),
        .irq(irq), .avmm_address(avmm_address), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .pretrig_ready(pretrig_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [16:0] wq[$];
    logic [31:0] rq[$];
    bit mon_en = 0, rd_seen = 0;
    bit exp_wen, exp_busy, exp_pr, exp_irq;

    // Behavioural model: phase 0 idle, 1 pre, 2 armed, 3 post, 4 done.
    int ph, m_pre, m_post, m_pre_l, m_post_l, m_wp, m_tp, m_n;
    bit m_done, m_short, m_stop, m_ext_en, m_irq_en, ext_prev, stop_prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_val(input int a);
        case (a)
            0: return {27'd0, m_irq_en, 2'b00, m_ext_en, 1'b0};
            1: return {25'd0, 3'(ph), m_stop, m_short, (ph >= 1 && ph <= 3), m_done};
            2: return 32'(m_pre);
            3: return 32'(m_post);
            4: return 32'(m_tp);
            5: return 32'(m_wp);
            default: return 32'hCCCC;
        endcase
    endfunction

    task automatic model_cycle();
        bit cw, arm, sw, ab, trig, stp, wen;
        logic [31:0] d;
        int a, nph;
        mon_en = 1;
        d = avmms_writedata;
        a = int'(avmms_address);
        if (avmms_reset) begin
            ph = 0; m_pre = 0; m_post = 0; m_pre_l = 0; m_post_l = 0; m_wp = 0; m_tp = 0; m_n = 0;
            m_done = 0; m_short = 0; m_stop = 0; m_ext_en = 0; m_irq_en = 0;
            ext_prev = 1; stop_prev = 1;
            exp_wen = 0; exp_busy = 0; exp_pr = 0; exp_irq = 0;
            return;
        end
        exp_busy = ph >= 1 && ph <= 3;
        exp_pr = ph == 2;
        exp_irq = m_done && m_irq_en;
        cw = avmms_cs && avmms_write;
        arm = cw && a == 0 && d[0];
        sw = cw && a == 0 && d[2];
        ab = cw && a == 0 && d[3];
        trig = sw || (m_ext_en && ext_start && !ext_prev);
        stp = stop_in && !stop_prev;
        wen = sample_valid && exp_busy && !(ph == 3 && m_n >= m_post_l) && !ab;
        exp_wen = wen;
        if (wen) wq.push_back({9'(m_wp), sample_data});
        if (avmms_cs && avmms_read) rq.push_back(reg_val(a));
        nph = ph;
        if (ab) nph = 0;
        else if ((ph == 0 || ph == 4) && arm) begin
            m_done = 0; m_short = 0; m_stop = 0; m_wp = 0; m_n = 0;
            m_pre_l = m_pre; m_post_l = m_post;
            nph = m_pre == 0 ? 2 : 1;
        end else if ((ph == 1 || ph == 2) && trig) begin
            m_tp = m_wp;
            m_n = wen ? 1 : 0;
            if (ph == 1) m_short = 1;
            nph = 3;
        end else begin
            if (ph == 1 && wen && m_n + 1 == m_pre_l) nph = 2;
            if (ph == 3) begin
                if (stp) m_stop = 1;
                if (stp || m_n >= m_post_l || (wen && m_n + 1 == m_post_l)) nph = 4;
            end
            if (wen) m_n++;
        end
        if (wen) m_wp = (m_wp + 1) % DEPTH;
        if (cw && a == 1 && d[0]) m_done = 0;
        if (nph == 4 && ph != 4) m_done = 1;
        if (cw && a == 0) begin m_ext_en = d[1]; m_irq_en = d[4]; end
        if (cw && a == 2) m_pre = d > DEPTH ? DEPTH : int'(d);
        if (cw && a == 3) m_post = d > DEPTH ? DEPTH : int'(d);
        ext_prev = ext_start;
        stop_prev = stop_in;
        ph = nph;
    endtask

    task automatic tick(input bit v);
        sample_valid = v;
        sample_data = 8'($urandom);
        model_cycle();
        @(posedge clk);
        #1;
        avmms_cs = 0; avmms_write = 0; avmms_read = 0;
    endtask

    task automatic wr(input int a, input int d, input bit v);
        avmms_cs = 1; avmms_write = 1; avmms_address = 3'(a); avmms_writedata = 32'(d);
        tick(v);
    endtask

    task automatic rd(input int a);
        avmms_cs = 1; avmms_read = 1; avmms_address = 3'(a);
        tick(0);
    endtask

    always @(posedge clk) rd_seen <= avmms_cs && avmms_read && !avmms_reset;

    always @(negedge clk) if (mon_en) begin
        logic [16:0] e;
        chk("avmm_write", 32'(avmm_write), 32'(exp_wen));
        if (avmm_write && wq.size() > 0) begin
            e = wq.pop_front();
            chk("wr_addr", 32'(avmm_address), 32'(e[16:8]));
            chk("wr_data", 32'(avmm_writedata), 32'(e[7:0]));
        end
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("pretrig_ready", 32'(pretrig_ready), 32'(exp_pr));
        chk("irq", 32'(irq), 32'(exp_irq));
        if (rd_seen) begin
            if (rq.size() == 0) chk("rd_expected", 32'(1), 32'(0));
            else chk("readdata", avmms_readdata, rq.pop_front());
        end
    end

    initial begin
        avmms_reset = 1; sample_valid = 0; sample_data = 0; ext_start = 0; stop_in = 0;
        avmms_cs = 0; avmms_write = 0; avmms_read = 0; avmms_address = 0; avmms_writedata = 0;
        tick(1); tick(1);
        avmms_reset = 0;
        for (int a = 0; a < 8; a++) rd(a);
        // Basic pre/post window with software trigger at write pointer 6.
        wr(2, 4, 0); wr(3, 3, 0); wr(0, 32'h11, 0);
        for (int i = 0; i < 6; i++) tick(1);
        rd(1);
        wr(0, 32'h14, 0);
        for (int i = 0; i < 3; i++) tick(1);
        tick(0); rd(1); rd(4); rd(5);
        wr(1, 1, 0); rd(1);
        // External edge trigger during PRE, then the same edge with EXT_EN off.
        wr(2, 8, 0); wr(0, 3, 0);
        for (int i = 0; i < 3; i++) tick(1);
        ext_start = 1; tick(0);
        rd(1); rd(4);
        for (int i = 0; i < 4; i++) tick(1);
        ext_start = 0;
        wr(0, 1, 0);
        for (int i = 0; i < 3; i++) tick(1);
        ext_start = 1; tick(0); rd(1);
        ext_start = 0; wr(0, 8, 0);
        // Zero pre-window and saturated post-window wrapping the whole RAM.
        wr(2, 0, 0); wr(3, DEPTH + 5, 0); rd(3);
        wr(0, 1, 0); wr(0, 4, 0);
        for (int i = 0; i < DEPTH + 3; i++) tick(1);
        rd(1); rd(4); rd(5);
        // Comparator stop after four post samples, with a sample in the edge cycle.
        wr(2, 2, 0); wr(3, 10, 0); wr(0, 1, 0);
        tick(1); tick(1);
        wr(0, 4, 0);
        for (int i = 0; i < 4; i++) tick(1);
        stop_in = 1; tick(1);
        stop_in = 0; tick(1);
        rd(1); rd(4); rd(5);
        // Abort mid-POST, reset mid-ARMED, ARM combined with SW_TRIG.
        wr(0, 32'h11, 0); tick(1); tick(1);
        wr(0, 32'h14, 0); tick(1); tick(1);
        wr(0, 32'h18, 0); rd(1); rd(5);
        wr(0, 32'h11, 0); tick(1); tick(1); tick(1);
        avmms_reset = 1; tick(1); avmms_reset = 0;
        for (int a = 0; a < 6; a++) rd(a);
        wr(2, 3, 0); wr(0, 5, 0); rd(1);
        tick(1); wr(0, 8, 0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 9) == 0) ext_start = ~ext_start;
            if ($urandom_range(0, 11) == 0) stop_in = ~stop_in;
            r = $urandom_range(0, 29);
            if (r < 2)
                wr(0, {27'd0, 1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom),
                       1'($urandom), 1'($urandom)}, 1'($urandom));
            else if (r == 2) wr(1, 1, 1'($urandom));
            else if (r == 3) wr(2, $urandom_range(0, 30) == 0 ? 600 : $urandom_range(0, 12), 1'($urandom));
            else if (r == 4) wr(3, $urandom_range(0, 30) == 0 ? 520 : $urandom_range(0, 12), 1'($urandom));
            else if (r < 7) rd($urandom_range(0, 7));
            else tick($urandom_range(0, 3) != 0);
        end
        tick(0); tick(0); tick(0);
        chk("wr_queue_drained", 32'(wq.size()), 32'(0));
        chk("rd_queue_drained", 32'(rq.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
